// File: rtl/alu_cmd_scheduler.sv
// Command scheduler in front of a 4-bit registered ALU: buffers tagged commands, issues one per
// cycle under a two-slot credit limit, and returns tagged results in order.
module alu_cmd_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_mode,
    input  logic [7:0]       alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_y,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_dz,
    output logic             busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned EntW = TAG_W + 11;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;
    state_e state_q, state_d;

    logic [EntW-1:0]  fifo_mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_mode_q, alu_mode_d;
    logic             inflight_q, inflight_d;
    logic [TAG_W-1:0] fl_tag_q, fl_tag_d;
    logic             fl_dz_q, fl_dz_d;
    logic [7:0]       rb_y_q [2];
    logic [TAG_W-1:0] rb_tag_q [2];
    logic             rb_dz_q [2];
    logic             rb_wr_q, rb_wr_d, rb_rd_q, rb_rd_d;
    logic [1:0]       rb_count_q, rb_count_d;

    logic             fifo_empty, fifo_full, push, issue, capture, res_pop;
    logic [1:0]       occ;
    logic [3:0]       head_a, head_b;
    logic [2:0]       head_mode;
    logic [TAG_W-1:0] head_tag;

    assign {head_tag, head_mode, head_b, head_a} = fifo_mem_q[rd_ptr_q];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign res_valid  = (rb_count_q != 2'd0);
    assign res_pop    = res_valid && res_ready;
    assign capture    = inflight_q;
    // Held plus in-flight results may never exceed the two buffer slots; a pop this cycle
    // frees a slot before the issued op is captured, which sustains one op per clock.
    assign occ        = rb_count_q + {1'b0, inflight_q};
    assign issue      = !fifo_empty && ((occ < 2'd2) || res_pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !issue) begin
            count_d = count_q + 1'b1;
        end else if (!push && issue) begin
            count_d = count_q - 1'b1;
        end
        alu_a_d    = issue ? head_a : alu_a_q;
        alu_b_d    = issue ? head_b : alu_b_q;
        alu_mode_d = issue ? head_mode : alu_mode_q;
        inflight_d = issue;
        fl_tag_d   = issue ? head_tag : fl_tag_q;
        fl_dz_d    = issue ? ((head_mode == 3'b011) && (head_b == 4'h0)) : fl_dz_q;
        rb_wr_d    = capture ? ~rb_wr_q : rb_wr_q;
        rb_rd_d    = res_pop ? ~rb_rd_q : rb_rd_q;
        rb_count_d = rb_count_q;
        if (capture && !res_pop) begin
            rb_count_d = rb_count_q + 2'd1;
        end else if (!capture && res_pop) begin
            rb_count_d = rb_count_q - 2'd1;
        end
    end

    always_comb begin
        state_d = StRun;
        unique case (state_q)
            StIdle:  state_d = (push || !fifo_empty || inflight_q) ? StRun : StIdle;
            StRun,
            StStall: begin
                if ((count_d == '0) && !inflight_d) begin
                    state_d = StIdle;
                end else if ((count_d != '0) && (rb_count_d == 2'd2)) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_mode_q <= 3'b000;
            inflight_q <= 1'b0;
            fl_tag_q   <= '0;
            fl_dz_q    <= 1'b0;
            rb_wr_q    <= 1'b0;
            rb_rd_q    <= 1'b0;
            rb_count_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
            inflight_q <= inflight_d;
            fl_tag_q   <= fl_tag_d;
            fl_dz_q    <= fl_dz_d;
            rb_wr_q    <= rb_wr_d;
            rb_rd_q    <= rb_rd_d;
            rb_count_q <= rb_count_d;
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_tag, cmd_mode, cmd_b, cmd_a};
        end
        if (capture && !rst) begin
            rb_y_q[rb_wr_q]   <= fl_dz_q ? 8'hFF : alu_y;
            rb_tag_q[rb_wr_q] <= fl_tag_q;
            rb_dz_q[rb_wr_q]  <= fl_dz_q;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_mode = alu_mode_q;
    assign res_y    = res_valid ? rb_y_q[rb_rd_q] : 8'h00;
    assign res_tag  = res_valid ? rb_tag_q[rb_rd_q] : '0;
    assign res_dz   = res_valid ? rb_dz_q[rb_rd_q] : 1'b0;
    assign busy     = (state_q != StIdle) || res_valid;

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed and randomised bench for alu_cmd_scheduler with a combinational stand-in for the
// ALU result path (operands are already registered inside the scheduler).
module tb_alu_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_tag;
    logic [2:0] cmd_mode;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_mode;
    logic [7:0] alu_y;
    logic       res_valid, res_ready, res_dz, busy;
    logic [7:0] res_y;
    logic [3:0] res_tag;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] got_y[$];
    logic [3:0] got_tag[$];
    logic       got_dz[$];
    int         got_cyc[$];

    alu_cmd_scheduler #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_tag(res_tag),
        .res_dz(res_dz), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_y(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] m);
        logic [7:0] xa, xb;
        xa = {4'h0, a};
        xb = {4'h0, b};
        case (m)
            3'd0:    return xa + xb;
            3'd1:    return xa - xb;
            3'd2:    return xa * xb;
            3'd3:    return (b == 4'h0) ? 8'hFF : xa / xb;
            3'd4:    return xa & xb;
            3'd5:    return xa | xb;
            3'd6:    return xa ^ xb;
            default: return ~xa;
        endcase
    endfunction

    // ALU stand-in; divide by zero returns 0 so a missing override is visible.
    always_comb begin
        alu_y = 8'h00;
        if (!(alu_mode == 3'd3 && alu_b == 4'h0)) alu_y = ref_y(alu_a, alu_b, alu_mode);
    end

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            got_y.push_back(res_y);
            got_tag.push_back(res_tag);
            got_dz.push_back(res_dz);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_got();
        got_y.delete(); got_tag.delete(); got_dz.delete(); got_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = 4'h0; cmd_b = 4'h0; cmd_mode = 3'd0; cmd_tag = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offers one command starting at posedge+1; returns just after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] m,
                        input logic [3:0] t);
        bit rdy;
        int guard = 0;
        cmd_a = a; cmd_b = b; cmd_mode = m; cmd_tag = t; cmd_valid = 1'b1;
        forever begin
            @(negedge clk) rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 500) begin
                n_cmp++; n_err++;
                $display("FAIL push_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, output bit ok);
        int g = 0;
        while (got_y.size() < n && g < 20000) begin
            @(posedge clk);
            g++;
        end
        #1;
        ok = (got_y.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, res_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b required 100",
                     {cmd_ready, res_valid, busy});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_mode, res_y, res_tag, res_dz} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_data: alu=%h/%h/%h res=%h/%h/%b required all zero",
                     alu_a, alu_b, alu_mode, res_y, res_tag, res_dz);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        clear_got();
        res_ready = 1'b1;
        push(4'd3, 4'd5, 3'd0, 4'd1);
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL lat_cycle1: res_valid=%b required 0", res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL lat_cycle2: res_valid=%b required 0", res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({res_valid, res_y, res_tag, res_dz} !== {1'b1, 8'h08, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL lat_cycle3: valid=%b y=%h tag=%h dz=%b required 1/08/1/0",
                     res_valid, res_y, res_tag, res_dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ey[4] = '{8'hE1, 8'hFF, 8'h0F, 8'hFF};
        bit ok;
        @(posedge clk); #1;
        clear_got();
        res_ready = 1'b1;
        push(4'hF, 4'hF, 3'd2, 4'd2);
        push(4'h2, 4'h3, 3'd1, 4'd3);
        push(4'hA, 4'h5, 3'd6, 4'd4);
        push(4'h0, 4'h0, 3'd7, 4'd5);
        wait_got(4, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL b2b_count: got %0d results required 4", got_y.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({got_y[i], got_tag[i], got_cyc[i] - got_cyc[0]} !==
                    {ey[i], 4'(i + 2), i}) begin
                    n_err++;
                    $display("FAIL b2b_%0d: y=%h tag=%h dcyc=%0d required %h/%h/%0d", i,
                             got_y[i], got_tag[i], got_cyc[i] - got_cyc[0], ey[i], i + 2, i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ey[6] = '{8'h03, 8'h08, 8'h0F, 8'h15, 8'h05, 8'h03};
        bit ok;
        @(posedge clk); #1;
        clear_got();
        res_ready = 1'b0;
        push(4'h1, 4'h2, 3'd0, 4'd6);
        push(4'hC, 4'hA, 3'd4, 4'd7);
        push(4'h5, 4'hA, 3'd5, 4'd8);
        push(4'h7, 4'h3, 3'd2, 4'd9);
        push(4'h9, 4'h4, 3'd1, 4'd10);
        push(4'hF, 4'h4, 3'd3, 4'd11);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({cmd_ready, res_valid, busy, res_y, res_tag, alu_a, alu_b, alu_mode} !==
                {1'b0, 1'b1, 1'b1, 8'h03, 4'd6, 4'hC, 4'hA, 3'd4}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: rdy=%b v=%b busy=%b y=%h tag=%h alu=%h/%h/%h required 0/1/1/03/6/c/a/4",
                         k, cmd_ready, res_valid, busy, res_y, res_tag, alu_a, alu_b, alu_mode);
            end
            repeat (4) @(negedge clk);
        end
        n_cmp++;
        if ({dut.count_q, dut.rb_count_q, dut.state_q} !== {3'd4, 2'd2, 2'd2}) begin
            n_err++;
            $display("FAIL bp_state: fifo=%0d held=%0d state=%0d required 4/2/2",
                     dut.count_q, dut.rb_count_q, dut.state_q);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_got(6, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL bp_count: got %0d results required 6", got_y.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if ({got_y[i], got_tag[i], got_dz[i]} !== {ey[i], 4'(i + 6), 1'b0}) begin
                    n_err++;
                    $display("FAIL bp_res_%0d: y=%h tag=%h dz=%b required %h/%h/0", i,
                             got_y[i], got_tag[i], got_dz[i], ey[i], i + 6);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] ey[3] = '{8'hFF, 8'h04, 8'h00};
        logic       ed[3] = '{1'b1, 1'b0, 1'b0};
        bit ok;
        @(posedge clk); #1;
        clear_got();
        res_ready = 1'b1;
        push(4'h9, 4'h0, 3'd3, 4'd12);
        push(4'h9, 4'h2, 3'd3, 4'd13);
        push(4'h9, 4'h0, 3'd2, 4'd14);
        wait_got(3, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL dz_count: got %0d results required 3", got_y.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({got_y[i], got_tag[i], got_dz[i]} !== {ey[i], 4'(i + 12), ed[i]}) begin
                    n_err++;
                    $display("FAIL dz_res_%0d: y=%h tag=%h dz=%b required %h/%h/%b", i,
                             got_y[i], got_tag[i], got_dz[i], ey[i], i + 12, ed[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        @(posedge clk); #1;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(4'(i), 4'h1, 3'd0, 4'(i));
        repeat (3) @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        n_cmp++;
        if ({dut.count_q, dut.inflight_q, dut.rb_count_q} !== {3'd3, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL rst_pre: fifo=%0d inflight=%b held=%0d required 3/1/1",
                     dut.count_q, dut.inflight_q, dut.rb_count_q);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({res_valid, busy, cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL rst_mid: valid/busy/ready=%b required 001",
                     {res_valid, busy, cmd_ready});
        end
        clear_got();
        @(posedge clk); #1;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (got_y.size() != 0) begin
            n_err++; $display("FAIL rst_stale: %0d results after reset required 0", got_y.size());
        end
        push(4'h1, 4'h1, 3'd0, 4'd3);
        wait_got(1, ok);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || got_y.size() != 1 || {got_y[0], got_tag[0]} !== {8'h02, 4'd3}) begin
            n_err++;
            $display("FAIL rst_after: count=%0d first=%h/%h required 1 result 02/3",
                     got_y.size(), ok ? got_y[0] : 8'hxx, ok ? got_tag[0] : 4'hx);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_y[$];
        logic [3:0] exp_tag[$];
        logic       exp_dz[$];
        bit         done = 1'b0;
        bit         ok;
        int         bad = 0;
        @(posedge clk); #1;
        clear_got();
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [3:0] a, b;
                    logic [2:0] m;
                    int gap;
                    a = 4'($urandom); b = 4'($urandom); m = 3'($urandom);
                    if ($urandom_range(0, 7) == 0) begin m = 3'd3; b = 4'h0; end
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin @(posedge clk); #1; end
                    push(a, b, m, 4'(i));
                    exp_y.push_back(ref_y(a, b, m));
                    exp_tag.push_back(4'(i));
                    exp_dz.push_back(m == 3'd3 && b == 4'h0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 9) < 7);
                end
                res_ready = 1'b1;
            end
        join
        wait_got(1000, ok);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || got_y.size() != 1000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rand_count: got %0d results busy=%b required 1000 and 0",
                     got_y.size(), busy);
        end else begin
            for (int i = 0; i < 1000; i++) begin
                n_cmp++;
                if ({got_y[i], got_tag[i], got_dz[i]} !== {exp_y[i], exp_tag[i], exp_dz[i]}) begin
                    n_err++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL rand_res_%0d: y=%h tag=%h dz=%b required %h/%h/%b", i,
                                 got_y[i], got_tag[i], got_dz[i], exp_y[i], exp_tag[i],
                                 exp_dz[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_div_zero();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
